// File: rtl/vga_readback.sv
// Framebuffer pixel read-back: fetches one pixel or eight horizontally adjacent
// pixels through the framebuffer read port and returns them as a CPU byte.
module vga_readback #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [7:0]        data,
  output logic              oor,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [8:0]        COL_LIM = 9'(WIDTH);
  localparam logic [7:0]        ROW_LIM = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

  state_t              state_reg, state_next;
  logic [7:0]          x_reg;
  logic                mode_reg;
  logic [ADDR_W-1:0]   row_base_reg;
  logic                y_ok_reg;
  logic                oor_pend_reg;
  logic [2:0]          issue_cnt_reg;
  logic                rd_en_reg, rd_en_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                cap_valid_reg, cap_en_reg;
  logic [2:0]          cap_bit_reg;
  logic [7:0]          asm_reg, asm_merged;
  logic [7:0]          data_reg;
  logic                oor_reg;

  logic                accept;
  logic                last_issue;
  logic                issue_now;
  logic [8:0]          issue_col;
  logic [ADDR_W-1:0]   issue_base;
  logic                issue_y_ok;
  logic [ADDR_W-1:0]   req_base;
  logic                req_y_ok;
  logic                req_oor;
  logic [8:0]          req_last_col;

  assign accept     = (state_reg == IDLE) && req;
  assign last_issue = (issue_cnt_reg == (mode_reg ? 3'd7 : 3'd0));

  // Range facts of an incoming request; column math is 9-bit so x+7 never wraps.
  assign req_base     = {{(ADDR_W-7){1'b0}}, y} * WIDTH_A;
  assign req_y_ok     = {1'b0, y} < ROW_LIM;
  assign req_last_col = {1'b0, x} + (mode ? 9'd7 : 9'd0);
  assign req_oor      = !req_y_ok || (req_last_col >= COL_LIM);

  always_comb begin
    state_next = state_reg;
    issue_now  = 1'b0;
    issue_col  = {1'b0, x_reg} + {6'b0, issue_cnt_reg} + 9'd1;
    issue_base = row_base_reg;
    issue_y_ok = y_ok_reg;
    case (state_reg)
      IDLE: begin
        issue_col  = {1'b0, x};
        issue_base = req_base;
        issue_y_ok = req_y_ok;
        if (req) begin
          issue_now  = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (last_issue) begin
          state_next = DRAIN;
        end else begin
          issue_now = 1'b1;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Out-of-range pixels are never read; the address register keeps its old value.
  always_comb begin
    rd_en_next = issue_now && issue_y_ok && (issue_col < COL_LIM);
    addr_next  = addr_reg;
    if (rd_en_next) begin
      addr_next = issue_base + {{(ADDR_W-9){1'b0}}, issue_col};
    end
  end

  // Read data arrives one cycle after the issue; merge it into its byte lane.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign asm_merged[gi] = (cap_valid_reg && (cap_bit_reg == 3'(gi)))
                          ? (cap_en_reg & mem_rdata) : asm_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      mode_reg      <= 1'b0;
      row_base_reg  <= '0;
      y_ok_reg      <= 1'b0;
      oor_pend_reg  <= 1'b0;
      issue_cnt_reg <= '0;
      rd_en_reg     <= 1'b0;
      addr_reg      <= '0;
      cap_valid_reg <= 1'b0;
      cap_en_reg    <= 1'b0;
      cap_bit_reg   <= '0;
      asm_reg       <= '0;
      data_reg      <= '0;
      oor_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_en_reg     <= rd_en_next;
      addr_reg      <= addr_next;
      cap_valid_reg <= (state_reg == READ);
      cap_en_reg    <= rd_en_reg;
      cap_bit_reg   <= issue_cnt_reg;
      if (accept) begin
        x_reg         <= x;
        mode_reg      <= mode;
        row_base_reg  <= req_base;
        y_ok_reg      <= req_y_ok;
        oor_pend_reg  <= req_oor;
        issue_cnt_reg <= '0;
        asm_reg       <= '0;
      end
      if (state_reg == READ && !last_issue) begin
        issue_cnt_reg <= issue_cnt_reg + 3'd1;
      end
      if (state_reg == READ || state_reg == DRAIN) begin
        asm_reg <= asm_merged;
      end
      if (state_reg == DRAIN) begin
        data_reg <= asm_merged;
        oor_reg  <= oor_pend_reg;
      end
    end
  end

  assign busy      = (state_reg == READ) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign data      = data_reg;
  assign oor       = oor_reg;
  assign mem_rd_en = rd_en_reg;
  assign mem_addr  = addr_reg;

endmodule

// File: tb/tb_vga_readback.sv
// Scoreboard bench for vga_readback: a framebuffer model answers reads, a monitor
// checks addresses and done results against expectations queued by the stimulus.
module tb_vga_readback;

  localparam int FB_SIZE = 160 * 120;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        mode;
  logic        busy;
  logic        done;
  logic [7:0]  data;
  logic        oor;
  logic        mem_rd_en;
  logic [14:0] mem_addr;
  logic        mem_rdata;

  typedef struct packed {
    logic [7:0]  d;
    logic        o;
    logic [31:0] c;
  } exp_t;

  exp_t        sb_q[$];
  logic [14:0] addr_q[$];
  logic        fb [0:FB_SIZE-1];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  vga_readback #(.WIDTH(160), .HEIGHT(120), .ADDR_W(15)) dut (
    .clk(clk), .reset(reset), .req(req), .x(x), .y(y), .mode(mode),
    .busy(busy), .done(done), .data(data), .oor(oor),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unrequested reads return 1 so missing zero-forcing shows up in the data.
  always @(posedge clk) mem_rdata <= mem_rd_en ? fb[mem_addr] : 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] a;
    if (mem_rd_en) begin
      if (addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got addr %0d expected no read (cycle %0d)", mem_addr, cyc);
      end else begin
        a = addr_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(a));
      end
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got data 0x%0h expected no done (cycle %0d)", data, cyc);
      end else begin
        e = sb_q.pop_front();
        $display("done: cycle %0d data=0x%02h oor=%0b", cyc, data, oor);
        check("data", 32'(data), 32'(e.d));
        check("oor", 32'(oor), 32'(e.o));
        check("done_cycle", 32'(cyc), e.c);
      end
    end
  end

  task automatic push_addrs(input int na, input int a0);
    for (int i = 0; i < na; i++) addr_q.push_back(15'(a0 + i));
  endtask

  // Issues one request from an IDLE negedge and returns at the following IDLE negedge.
  task automatic do_req(input logic [7:0] rx, input logic [6:0] ry, input logic rm,
                        input logic [7:0] ed, input logic eo, input int na, input int a0);
    int n;
    int e0;
    exp_t e;
    n  = rm ? 8 : 1;
    e0 = cyc + 1;
    e.d = ed;
    e.o = eo;
    e.c = 32'(e0 + n + 1);
    sb_q.push_back(e);
    push_addrs(na, a0);
    x = rx; y = ry; mode = rm; req = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      req = 1'b0;
      check("busy", 32'(busy), 32'(k <= n + 1));
    end
    @(negedge clk);
  endtask

  initial begin
    int   e0;
    exp_t e;
    for (int i = 0; i < FB_SIZE; i++) fb[i] = 1'b0;
    fb[810] = 1'b1;
    fb[0] = 1'b1; fb[2] = 1'b1; fb[3] = 1'b1; fb[7] = 1'b1;
    for (int c = 156; c < 160; c++) fb[119*160 + c] = 1'b1;

    reset = 1'b1; req = 1'b0; x = '0; y = '0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(data), 0);
    check("rst_oor", 32'(oor), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    do_req(8'd10,  7'd5,   1'b0, 8'h01, 1'b0, 1, 810);
    do_req(8'd0,   7'd0,   1'b1, 8'h8D, 1'b0, 8, 0);
    do_req(8'd156, 7'd119, 1'b1, 8'h0F, 1'b1, 4, 19196);
    do_req(8'd0,   7'd120, 1'b0, 8'h00, 1'b1, 0, 0);
    do_req(8'd159, 7'd119, 1'b0, 8'h01, 1'b0, 1, 19199);
    do_req(8'd152, 7'd119, 1'b1, 8'hF0, 1'b0, 8, 19192);
    do_req(8'd153, 7'd119, 1'b1, 8'h78, 1'b1, 7, 19193);
    do_req(8'd160, 7'd0,   1'b0, 8'h00, 1'b1, 0, 0);
    do_req(8'd255, 7'd0,   1'b1, 8'h00, 1'b1, 0, 0);
    do_req(8'd200, 7'd3,   1'b1, 8'h00, 1'b1, 0, 0);

    // req held high during a busy mode-1 read must not be queued
    e0 = cyc + 1;
    e.d = 8'h8D; e.o = 1'b0; e.c = 32'(e0 + 9);
    sb_q.push_back(e);
    push_addrs(8, 0);
    x = 8'd0; y = 7'd0; mode = 1'b1; req = 1'b1;
    @(negedge clk);
    x = 8'd10; y = 7'd5; mode = 1'b0;
    repeat (5) @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);

    // reset in cycle 4 of a mode-1 read aborts it
    push_addrs(4, 0);
    x = 8'd0; y = 7'd0; mode = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_data", 32'(data), 0);
    check("abort_oor", 32'(oor), 0);
    check("abort_rd_en", 32'(mem_rd_en), 0);
    check("abort_addr", 32'(mem_addr), 0);
    repeat (12) @(negedge clk);
    do_req(8'd10, 7'd5, 1'b0, 8'h01, 1'b0, 1, 810);

    // back-to-back with req held: second accepted at the IDLE edge after DONE
    e0 = cyc + 1;
    e.d = 8'h01; e.o = 1'b0; e.c = 32'(e0 + 2);
    sb_q.push_back(e);
    e.d = 8'h00; e.o = 1'b0; e.c = 32'(e0 + 6);
    sb_q.push_back(e);
    push_addrs(1, 810);
    push_addrs(1, 811);
    x = 8'd10; y = 7'd5; mode = 1'b0; req = 1'b1;
    @(negedge clk);
    x = 8'd11;
    repeat (3) @(negedge clk);
    check("hold_idle_data", 32'(data), 32'h01);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("hold_busy_data", 32'(data), 32'h01);
    repeat (4) @(negedge clk);

    check("pending_done", 32'(sb_q.size()), 0);
    check("pending_reads", 32'(addr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_readback.md
Name: vga_readback

Overview:
Read-side counterpart to the VGA plot path. The CPU writes pixels into the 1-bit framebuffer through x/y/colour/plot. This block lets the CPU read pixels back from the framebuffer's second (read) port. It accepts a coordinate request and fetches either one pixel or 8 horizontally adjacent pixels. The result is returned as a byte suitable for the CPU's 8-bit input bus (e4), with a busy/done handshake.

Parameters:
WIDTH, 160, framebuffer width in pixels
HEIGHT, 120, framebuffer height in pixels
ADDR_W, 15, framebuffer read-port address width (must be wide enough for WIDTH*HEIGHT-1)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  request strobe; sampled only in IDLE
x  input  8  start column
y  input  7  row
mode  input  1  0 = single pixel, 1 = 8-pixel byte
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse; data is valid in this cycle
data  output  8  result; held until the next done
oor  output  1  out-of-range flag for the last request; updated with done
mem_rd_en  output  1  framebuffer read enable
mem_addr  output  ADDR_W  framebuffer read address = y*WIDTH + pixel column
mem_rdata  input  1  framebuffer read data; valid the cycle after mem_rd_en

Behaviour:
- Reset: state=IDLE; busy=0, done=0, data=8'h00, oor=0, mem_rd_en=0, mem_addr=0. Reset asserted mid-request aborts it with no done pulse.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On req=1 at edge E0: latch x, y and mode; set N=1 (mode 0) or N=8 (mode 1); clear the shift/assembly register; go to READ.
  - req while not in IDLE is ignored; it is not queued.
- READ: lasts cycles 1..N after E0.
  - In cycle i, issue pixel column px = x+i-1.
  - mem_addr = y*WIDTH + px, computed at ADDR_W width with no truncation for legal y.
  - mem_rd_en=1 only if px < WIDTH and y < HEIGHT. Otherwise mem_rd_en=0 and that pixel is forced to 0.
  - Column arithmetic is 9-bit, so x+7 does not wrap past 255. There is no row wrap: pixels beyond WIDTH-1 read as 0.
- Capture:
  - The pixel issued in cycle c is captured at the end of cycle c+1 into data bit (c-1), i.e. data[k] = pixel at column x+k.
  - Mode 0: data = {7'b0, pixel}.
  - Reads are pipelined: one issue per cycle, capture overlapping the next issue.
- DRAIN: cycle N+1; no issue; last capture.
- DONE: cycle N+2.
  - done=1; data and oor updated and valid.
  - Back to IDLE next cycle; a new req can be sampled at the end of the DONE cycle's following edge.
- Latency (req edge to done cycle): mode 0 = 3 cycles; mode 1 = 10 cycles. Latency is fixed and independent of range.
- busy=1 in cycles 1..N+1; busy=0 in DONE and IDLE.
- oor=1 if y >= HEIGHT, or any requested column >= WIDTH. A partially out-of-range byte still returns its in-range pixels.
- mem_addr holds its last value when mem_rd_en=0.
- The output data register changes only on done.

Test Plan:
- Mode 0, framebuffer pixel (10,5)=1 -> mem_addr=810 in cycle 1; done in cycle 3; data=8'h01; oor=0; busy high in cycles 1-2 only.
- Mode 1, x=0, y=0, pixels 0..7 = 1,0,1,1,0,0,0,1 -> addresses 0..7 on consecutive cycles; done in cycle 10; data=8'h8D.
- Mode 1, x=156, y=119, pixels 156..159 all 1 -> addresses 19196..19199; no rd_en for cols 160-163; data=8'h0F; oor=1.
- Mode 0, y=120 -> mem_rd_en never asserted; done in cycle 3; data=8'h00; oor=1.
- req re-asserted during busy -> ignored, single done; reset asserted in cycle 4 of a mode-1 read -> no done, all outputs 0 the next cycle, new req accepted afterwards.
- Back-to-back requests with req held high -> the second request is accepted the cycle after DONE; data from the first request is held until the second done.
